// File: rtl/clock_ctrl_pkg.sv
// Shared types and limits for the clock time-setting controller.
// Field widths and wrap limits match the digital_clock datapath.
package clock_ctrl_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
    localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        COMMIT   = 2'd3
    } set_state_t;

endpackage

// File: rtl/btn_repeat.sv
// Button rising-edge detector with optional hold-to-repeat.
// REPEAT_DELAY of 0 builds a plain edge detector with no repeat.
module btn_repeat #(
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic evt
);

    logic prev;
    logic rise;
    logic rpt;

    assign rise = btn & ~prev;
    assign evt  = rise | rpt;

    // Previous button sample for edge detection
    always_ff @(posedge clk) begin
        if (reset) prev <= 1'b0;
        else       prev <= btn;
    end

    generate
        if (REPEAT_DELAY > 0) begin : g_rep
            localparam int MAXC = (REPEAT_DELAY > REPEAT_RATE) ?
                                  REPEAT_DELAY : REPEAT_RATE;
            localparam int CW = $clog2(MAXC + 1) + 1;

            logic [CW-1:0] cnt;
            logic          rep;

            assign rpt = btn & prev &
                         (rep ? (cnt == CW'(REPEAT_RATE))
                              : (cnt == CW'(REPEAT_DELAY)));

            // Cycles since last event; rep marks the fast-rate phase
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt <= '0;
                    rep <= 1'b0;
                end else if (!btn) begin
                    cnt <= '0;
                    rep <= 1'b0;
                end else if (rise) begin
                    cnt <= CW'(1);
                    rep <= 1'b0;
                end else if (rpt) begin
                    cnt <= CW'(1);
                    rep <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end else begin : g_norep
            assign rpt = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: pauses the clock, edits hour/minute
// in shadow registers and commits them with a one-cycle load.
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 10_000_000,
    parameter int TIMEOUT      = 1_000_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    output logic              run_en,
    output logic              load,
    output logic [HOUR_W-1:0] load_hour,
    output logic [MIN_W-1:0]  load_min,
    output logic [SEC_W-1:0]  load_sec,
    output logic [1:0]        set_mode,
    output logic [HOUR_W-1:0] disp_hour,
    output logic [MIN_W-1:0]  disp_min
);

    localparam int TW = $clog2(TIMEOUT + 1);

    set_state_t        state;
    set_state_t        state_nx;
    logic              mode_ev;
    logic              inc_ev;
    logic              editing;
    logic              timeout_hit;
    logic [TW-1:0]     idle_cnt;
    logic [HOUR_W-1:0] sh_hour;
    logic [MIN_W-1:0]  sh_min;

    btn_repeat #(
        .REPEAT_DELAY(0),
        .REPEAT_RATE (0)
    ) u_mode (
        .clk  (clk),
        .reset(reset),
        .btn  (btn_mode),
        .evt  (mode_ev)
    );

    btn_repeat #(
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_inc (
        .clk  (clk),
        .reset(reset),
        .btn  (btn_inc),
        .evt  (inc_ev)
    );

    assign editing     = (state == SET_HOUR) || (state == SET_MIN);
    assign timeout_hit = editing && !mode_ev && !inc_ev &&
                         (idle_cnt == TW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_nx;
    end

    // Next-state: mode edges advance, idle timeout abandons the edit
    always_comb begin
        state_nx = state;
        unique case (state)
            RUN:      if (mode_ev) state_nx = SET_HOUR;
            SET_HOUR: begin
                if (mode_ev)          state_nx = SET_MIN;
                else if (timeout_hit) state_nx = RUN;
            end
            SET_MIN:  begin
                if (mode_ev)          state_nx = COMMIT;
                else if (timeout_hit) state_nx = RUN;
            end
            COMMIT:   state_nx = RUN;
            default:  state_nx = RUN;
        endcase
    end

    // Idle counter, live only while editing and cleared by any event
    always_ff @(posedge clk) begin
        if (reset)                          idle_cnt <= '0;
        else if (!editing || mode_ev || inc_ev) idle_cnt <= '0;
        else                                idle_cnt <= idle_cnt + 1'b1;
    end

    // Shadow time: capture on entry, increment the active field
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_hour <= '0;
            sh_min  <= '0;
        end else if (state == RUN && mode_ev) begin
            sh_hour <= cur_hour;
            sh_min  <= cur_min;
        end else if (inc_ev && !mode_ev) begin
            if (state == SET_HOUR)
                sh_hour <= (sh_hour >= MAX_HOUR) ? '0 : sh_hour + 1'b1;
            else if (state == SET_MIN)
                sh_min <= (sh_min >= MAX_MIN) ? '0 : sh_min + 1'b1;
        end
    end

    // Load values latch on the way into COMMIT and hold afterwards
    always_ff @(posedge clk) begin
        if (reset) begin
            load_hour <= '0;
            load_min  <= '0;
        end else if (state == SET_MIN && mode_ev) begin
            load_hour <= sh_hour;
            load_min  <= sh_min;
        end
    end

    assign run_en    = (state == RUN);
    assign load      = (state == COMMIT);
    assign load_sec  = '0;
    assign set_mode  = state;
    assign disp_hour = (state == RUN) ? cur_hour : sh_hour;
    assign disp_min  = (state == RUN) ? cur_min  : sh_min;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with a load scoreboard.
// Expected commits are queued when the edit is driven.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic       run_en;
    logic       load;
    logic [4:0] load_hour;
    logic [5:0] load_min;
    logic [5:0] load_sec;
    logic [1:0] set_mode;
    logic [4:0] disp_hour;
    logic [5:0] disp_min;

    int checks = 0;
    int errors = 0;
    int loads  = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    clock_set_ctrl #(
        .REPEAT_DELAY(8),
        .REPEAT_RATE (4),
        .TIMEOUT     (50)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .cur_hour (cur_hour),
        .cur_min  (cur_min),
        .run_en   (run_en),
        .load     (load),
        .load_hour(load_hour),
        .load_min (load_min),
        .load_sec (load_sec),
        .set_mode (set_mode),
        .disp_hour(disp_hour),
        .disp_min (disp_min)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        tick();
    endtask

    task automatic press_inc();
        btn_inc = 1'b1;
        tick();
        btn_inc = 1'b0;
        tick();
    endtask

    // Scoreboard: every load pulse pops one expected {hour,min,sec}
    always @(negedge clk) begin
        if (!reset && load === 1'b1) begin
            loads++;
            if (exp_q.size() == 0) begin
                chk("unexpected_load", 1, 0);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("load_hour", int'(load_hour), (e >> 12) & 31);
                chk("load_min",  int'(load_min),  (e >> 6) & 63);
                chk("load_sec",  int'(load_sec),  e & 63);
            end
        end
    end

    initial begin
        reset    = 1'b1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        cur_hour = 5'd12;
        cur_min  = 6'd34;
        tick();
        tick();
        reset = 1'b0;
        tick();

        chk("rst_run_en",   int'(run_en),    1);
        chk("rst_set_mode", int'(set_mode),  0);
        chk("rst_load",     int'(load),      0);
        chk("rst_load_h",   int'(load_hour), 0);
        chk("rst_disp_h",   int'(disp_hour), 12);
        chk("rst_disp_m",   int'(disp_min),  34);

        // Full edit: 22:58 -> hour +2 -> 0, min +3 -> 1
        cur_hour = 5'd22;
        cur_min  = 6'd58;
        press_mode();
        chk("edit_mode_h",  int'(set_mode),  1);
        chk("edit_run_h",   int'(run_en),    0);
        chk("edit_cap_h",   int'(disp_hour), 22);
        chk("edit_cap_m",   int'(disp_min),  58);
        press_inc();
        chk("hour_23",      int'(disp_hour), 23);
        press_inc();
        chk("hour_wrap",    int'(disp_hour), 0);
        press_mode();
        chk("edit_mode_m",  int'(set_mode),  2);
        chk("edit_run_m",   int'(run_en),    0);
        press_inc();
        press_inc();
        chk("min_wrap",     int'(disp_min),  0);
        chk("hour_keep",    int'(disp_hour), 0);
        press_inc();
        chk("min_one",      int'(disp_min),  1);
        exp_q.push_back((0 << 12) | (1 << 6) | 0);
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        chk("commit_mode",  int'(set_mode),  3);
        chk("commit_run",   int'(run_en),    0);
        chk("commit_load",  int'(load),      1);
        tick();
        tick();
        chk("post_run_en",  int'(run_en),    1);
        chk("post_mode",    int'(set_mode),  0);
        chk("post_load",    int'(load),      0);
        chk("hold_load_h",  int'(load_hour), 0);
        chk("hold_load_m",  int'(load_min),  1);

        // Auto-repeat: hold 20 cycles from minute 0
        cur_hour = 5'd3;
        cur_min  = 6'd0;
        press_mode();
        press_mode();
        chk("rep_mode",     int'(set_mode),  2);
        btn_inc = 1'b1;
        repeat (20) tick();
        btn_inc = 1'b0;
        tick();
        chk("rep_min",      int'(disp_min),  4);
        chk("rep_hour",     int'(disp_hour), 3);
        exp_q.push_back((3 << 12) | (4 << 6) | 0);
        press_mode();
        tick();
        chk("rep_done",     int'(set_mode),  0);

        // Simultaneous mode and inc in SET_HOUR
        cur_hour = 5'd5;
        cur_min  = 6'd10;
        press_mode();
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        tick();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        tick();
        chk("sim_mode",     int'(set_mode),  2);
        chk("sim_hour",     int'(disp_hour), 5);
        chk("sim_min",      int'(disp_min),  10);
        exp_q.push_back((5 << 12) | (10 << 6) | 0);
        press_mode();
        tick();
        chk("sim_done",     int'(set_mode),  0);

        // Idle timeout abandons the edit without a load
        cur_hour = 5'd7;
        cur_min  = 6'd20;
        press_mode();
        press_inc();
        chk("to_inc",       int'(disp_hour), 8);
        repeat (40) tick();
        chk("to_still_set", int'(set_mode),  1);
        repeat (15) tick();
        chk("to_mode",      int'(set_mode),  0);
        chk("to_run_en",    int'(run_en),    1);
        chk("to_disp_h",    int'(disp_hour), 7);
        chk("to_load_h",    int'(load_hour), 5);
        chk("to_load_m",    int'(load_min),  10);

        // Reset in the middle of SET_MIN
        press_mode();
        press_mode();
        press_inc();
        chk("mr_mode",      int'(set_mode),  2);
        reset = 1'b1;
        tick();
        chk("mr_set_mode",  int'(set_mode),  0);
        chk("mr_run_en",    int'(run_en),    1);
        chk("mr_load",      int'(load),      0);
        chk("mr_load_h",    int'(load_hour), 0);
        chk("mr_load_m",    int'(load_min),  0);
        chk("mr_load_s",    int'(load_sec),  0);
        reset = 1'b0;
        tick();
        tick();
        chk("mr_disp_m",    int'(disp_min),  20);

        chk("loads_total",  loads,           3);
        chk("queue_empty",  exp_q.size(),    0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
